// File: rtl/fft2d_tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft2d_tdp_ram_pkg
// Description : Shared FFT2D defaults and helpers for the row/column buffer RAM.
// Revision    : 1.0
// ============================================================================
package fft2d_tdp_ram_pkg;

    localparam int FFT_DATA_WIDTH = 32;
    localparam int FFT2D_ROW_BITS = 3;
    localparam int FFT2D_COL_BITS = 3;
    localparam int FFT2D_RD_LAT   = 1;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic bit rd_lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft2d_ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fft2d_ram_rd_pipe
// Description : Per-port read data/valid pipeline (1 or 2 stages) with RDW bypass.
// Revision    : 1.0
// ============================================================================
module fft2d_ram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              byp_sel,
    input  logic [DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0] dout,
    output logic              vld
);

    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_vld;

    assign w_rd_data = byp_sel ? byp_data : mem_data;

    // Data registers load only on a valid beat so dout holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_data <= '0;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_vld <= rd_req;
            if (rd_req) begin
                r_s1_data <= w_rd_data;
            end
        end
    end

    generate
        if (RD_LAT >= 2) begin : g_lat2
            logic [DATA_W-1:0] r_s2_data;
            logic              r_s2_vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s2_data <= '0;
                    r_s2_vld  <= 1'b0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign dout = r_s2_data;
            assign vld  = r_s2_vld;
        end else begin : g_lat1
            assign dout = r_s1_data;
            assign vld  = r_s1_vld;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fft2d_tdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : fft2d_tdp_ram
// Description : True dual-port RAM with transpose addressing, RD_LAT pipeline,
//               port-A-wins write collision and selectable read-during-write.
// Revision    : 1.0
// ============================================================================
module fft2d_tdp_ram
    import fft2d_tdp_ram_pkg::*;
#(
    parameter int DATA_W       = FFT_DATA_WIDTH,
    parameter int ROW_BITS     = FFT2D_ROW_BITS,
    parameter int COL_BITS     = FFT2D_COL_BITS,
    parameter int RD_LAT       = FFT2D_RD_LAT,
    parameter int RDW_MODE     = RDW_OLD,
    parameter int TRANSPOSE_EN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_en,
    input  logic                         a_we,
    input  logic                         a_tr,
    input  logic [ROW_BITS+COL_BITS-1:0] a_addr,
    input  logic [DATA_W-1:0]            a_din,
    output logic [DATA_W-1:0]            a_dout,
    output logic                         a_vld,
    input  logic                         b_en,
    input  logic                         b_we,
    input  logic                         b_tr,
    input  logic [ROW_BITS+COL_BITS-1:0] b_addr,
    input  logic [DATA_W-1:0]            b_din,
    output logic [DATA_W-1:0]            b_dout,
    output logic                         b_vld,
    output logic                         coll_ww
);

    localparam int c_addr_w = ROW_BITS + COL_BITS;
    localparam int c_depth  = 1 << c_addr_w;

    generate
        if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
            $error("fft2d_tdp_ram: RD_LAT must be 1 or 2");
        end
        if ((TRANSPOSE_EN != 0) && (ROW_BITS != COL_BITS)) begin : g_bad_geom
            $error("fft2d_tdp_ram: ROW_BITS must equal COL_BITS when TRANSPOSE_EN=1");
        end
    endgenerate

    logic [DATA_W-1:0]   r_mem [c_depth];
    logic [c_addr_w-1:0] w_a_eff;
    logic [c_addr_w-1:0] w_b_eff;
    logic                w_a_wr, w_a_rd, w_b_wr, w_b_rd, w_same;
    logic                w_a_byp, w_b_byp;
    logic                r_run;
    logic                r_coll_ww;

    // r_run stays low through the first edge after reset release, so that edge is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_a_eff = (a_tr && (TRANSPOSE_EN != 0)) ?
                     {a_addr[COL_BITS-1:0], a_addr[c_addr_w-1:COL_BITS]} : a_addr;
    assign w_b_eff = (b_tr && (TRANSPOSE_EN != 0)) ?
                     {b_addr[COL_BITS-1:0], b_addr[c_addr_w-1:COL_BITS]} : b_addr;

    assign w_a_wr = r_run && a_en && a_we;
    assign w_a_rd = r_run && a_en && !a_we;
    assign w_b_wr = r_run && b_en && b_we;
    assign w_b_rd = r_run && b_en && !b_we;
    assign w_same = (w_a_eff == w_b_eff);

    assign w_a_byp = (RDW_MODE == RDW_NEW) && w_b_wr && w_same;
    assign w_b_byp = (RDW_MODE == RDW_NEW) && w_a_wr && w_same;

    // Port A write is issued last, so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (w_b_wr) begin
            r_mem[w_b_eff] <= b_din;
        end
        if (w_a_wr) begin
            r_mem[w_a_eff] <= a_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll_ww <= 1'b0;
        end else begin
            r_coll_ww <= w_a_wr && w_b_wr && w_same;
        end
    end

    assign coll_ww = r_coll_ww;

    fft2d_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (w_a_rd),
        .mem_data (r_mem[w_a_eff]),
        .byp_sel  (w_a_byp),
        .byp_data (b_din),
        .dout     (a_dout),
        .vld      (a_vld)
    );

    fft2d_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (w_b_rd),
        .mem_data (r_mem[w_b_eff]),
        .byp_sel  (w_b_byp),
        .byp_data (a_din),
        .dout     (b_dout),
        .vld      (b_vld)
    );

endmodule
`default_nettype wire

// File: tb/tb_fft2d_tdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft2d_tdp_ram
// Description : Two RAM configurations (RD_LAT=1/old-data, RD_LAT=2/new-data)
//               driven in lockstep and compared against a word-array model.
// Revision    : 1.0
// ============================================================================
module tb_fft2d_tdp_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_we, a_tr, b_en, b_we, b_tr;
    logic [5:0]  a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic [31:0] a_dout1, b_dout1, a_dout2, b_dout2;
    logic        a_vld1, b_vld1, a_vld2, b_vld2, coll1, coll2;

    always #5 clk = ~clk;

    fft2d_tdp_ram #(
        .DATA_W(32), .ROW_BITS(3), .COL_BITS(3), .RD_LAT(1), .RDW_MODE(0), .TRANSPOSE_EN(1)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_tr(a_tr), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout1), .a_vld(a_vld1),
        .b_en(b_en), .b_we(b_we), .b_tr(b_tr), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout1), .b_vld(b_vld1),
        .coll_ww(coll1)
    );

    fft2d_tdp_ram #(
        .DATA_W(32), .ROW_BITS(3), .COL_BITS(3), .RD_LAT(2), .RDW_MODE(1), .TRANSPOSE_EN(1)
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_tr(a_tr), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout2), .a_vld(a_vld2),
        .b_en(b_en), .b_we(b_we), .b_tr(b_tr), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout2), .b_vld(b_vld2),
        .coll_ww(coll2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: word array plus expected outputs for [config][port].
    logic [31:0] m_mem [64];
    bit          m_armed;
    logic        e_vld  [2][2];
    logic [31:0] e_dout [2][2];
    logic        e_coll;
    logic        pend_vld  [2];
    logic [31:0] pend_data [2];

    function automatic logic [5:0] eff(input logic tr, input logic [5:0] ad);
        return tr ? {ad[2:0], ad[5:3]} : ad;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                e_vld[c][p]  = 1'b0;
                e_dout[c][p] = '0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            pend_vld[p]  = 1'b0;
            pend_data[p] = '0;
        end
        e_coll  = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic model_edge();
        logic        en [2];
        logic        we [2];
        logic        rd [2];
        logic        wr [2];
        logic [5:0]  ea [2];
        logic [31:0] din [2];
        logic [31:0] old_w, new_w;
        int          q;
        en[0] = a_en; we[0] = a_we; ea[0] = eff(a_tr, a_addr); din[0] = a_din;
        en[1] = b_en; we[1] = b_we; ea[1] = eff(b_tr, b_addr); din[1] = b_din;
        if (!m_armed) begin
            en[0]   = 1'b0;
            en[1]   = 1'b0;
            m_armed = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            rd[p] = en[p] && !we[p];
            wr[p] = en[p] && we[p];
        end
        e_coll = wr[0] && wr[1] && (ea[0] == ea[1]);
        for (int p = 0; p < 2; p++) begin
            q     = 1 - p;
            old_w = m_mem[ea[p]];
            new_w = (wr[q] && ea[q] == ea[p]) ? din[q] : old_w;
            e_vld[0][p] = rd[p];
            if (rd[p]) e_dout[0][p] = old_w;
            e_vld[1][p] = pend_vld[p];
            if (pend_vld[p]) e_dout[1][p] = pend_data[p];
            pend_vld[p] = rd[p];
            if (rd[p]) pend_data[p] = new_w;
        end
        if (wr[1]) m_mem[ea[1]] = din[1];
        if (wr[0]) m_mem[ea[0]] = din[0];
    endtask

    task automatic compare_all();
        check("l1_a_vld",  32'(a_vld1), 32'(e_vld[0][0]));
        check("l1_b_vld",  32'(b_vld1), 32'(e_vld[0][1]));
        check("l1_a_dout", a_dout1,     e_dout[0][0]);
        check("l1_b_dout", b_dout1,     e_dout[0][1]);
        check("l1_coll",   32'(coll1),  32'(e_coll));
        check("l2_a_vld",  32'(a_vld2), 32'(e_vld[1][0]));
        check("l2_b_vld",  32'(b_vld2), 32'(e_vld[1][1]));
        check("l2_a_dout", a_dout2,     e_dout[1][0]);
        check("l2_b_dout", b_dout2,     e_dout[1][1]);
        check("l2_coll",   32'(coll2),  32'(e_coll));
    endtask

    task automatic drive(input logic ae, input logic awe, input logic atr,
                         input logic [5:0] aad, input logic [31:0] ad,
                         input logic be, input logic bwe, input logic btr,
                         input logic [5:0] bad, input logic [31:0] bd);
        a_en = ae; a_we = awe; a_tr = atr; a_addr = aad; a_din = ad;
        b_en = be; b_we = bwe; b_tr = btr; b_addr = bad; b_din = bd;
    endtask

    task automatic do_edge();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic step(input logic ae, input logic awe, input logic atr,
                        input logic [5:0] aad, input logic [31:0] ad,
                        input logic be, input logic bwe, input logic btr,
                        input logic [5:0] bad, input logic [31:0] bd);
        @(negedge clk);
        drive(ae, awe, atr, aad, ad, be, bwe, btr, bad, bd);
        do_edge();
    endtask

    task automatic idle();
        step(0, 0, 0, 6'h0, 32'h0, 0, 0, 0, 6'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 6'h0, 32'h0, 0, 0, 0, 6'h0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();

        @(negedge clk);
        rst = 1'b0;
        do_edge();

        // Write then read on the other port
        step(1, 1, 0, 6'h05, 32'h11111111, 0, 0, 0, 6'h00, 32'h0);
        step(0, 0, 0, 6'h00, 32'h0,        1, 0, 0, 6'h05, 32'h0);
        check("t1_b_vld",  32'(b_vld1), 32'h1);
        check("t1_b_dout", b_dout1, 32'h11111111);
        idle();
        check("t1_b_dout_l2", b_dout2, 32'h11111111);

        // Write-write collision, port A wins
        step(1, 1, 0, 6'h12, 32'hAAAA0000, 1, 1, 0, 6'h12, 32'h0000BBBB);
        check("t2_coll", 32'(coll1), 32'h1);
        step(1, 0, 0, 6'h12, 32'h0, 0, 0, 0, 6'h00, 32'h0);
        check("t2_coll_clr", 32'(coll1), 32'h0);
        check("t2_a_dout",   a_dout1, 32'hAAAA0000);
        idle();
        check("t2_a_dout_l2", a_dout2, 32'hAAAA0000);

        // Read-during-write across ports
        step(1, 1, 0, 6'h09, 32'h1, 0, 0, 0, 6'h00, 32'h0);
        step(1, 1, 0, 6'h09, 32'h2, 1, 0, 0, 6'h09, 32'h0);
        check("t3_old", b_dout1, 32'h1);
        idle();
        check("t3_new", b_dout2, 32'h2);

        // Fill with 0x100+k, then transposed read
        for (int k = 0; k < 64; k += 2) begin
            step(1, 1, 0, 6'(k), 32'h100 + 32'(k), 1, 1, 0, 6'(k + 1), 32'h101 + 32'(k));
        end
        step(1, 0, 1, 6'h0A, 32'h0, 0, 0, 0, 6'h00, 32'h0);
        check("t4_tr", a_dout1, 32'h111);
        idle();
        check("t4_tr_l2", a_dout2, 32'h111);

        // Back-to-back reads through the two-stage pipeline
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 6'h00, 32'h0, 1, 0, 0, 6'(i), 32'h0);
            if (i == 0) begin
                check("t5_vld_early", 32'(b_vld2), 32'h0);
            end else begin
                check("t5_vld",  32'(b_vld2), 32'h1);
                check("t5_data", b_dout2, 32'h100 + 32'(i - 1));
            end
        end
        idle();
        check("t5_last", b_dout2, 32'h107);
        idle();
        check("t5_vld_end", 32'(b_vld2), 32'h0);
        check("t5_hold",    b_dout2, 32'h107);

        // Asynchronous reset with reads in flight
        step(1, 0, 0, 6'h03, 32'h0, 0, 0, 0, 6'h00, 32'h0);
        step(1, 0, 0, 6'h04, 32'h0, 0, 0, 0, 6'h00, 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 6'h05, 32'h0, 0, 0, 0, 6'h00, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("t6_a_vld1",  32'(a_vld1), 32'h0);
        check("t6_a_dout1", a_dout1, 32'h0);
        check("t6_a_vld2",  32'(a_vld2), 32'h0);
        check("t6_a_dout2", a_dout2, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 6'h20, 32'h00000BAD, 0, 0, 0, 6'h00, 32'h0);
        do_edge();
        idle();
        check("t6_no_stale", 32'(a_vld2), 32'h0);
        step(1, 0, 0, 6'h20, 32'h0, 1, 0, 0, 6'h05, 32'h0);
        check("t6_kept",   a_dout1, 32'h120);
        check("t6_kept_b", b_dout1, 32'h105);
        idle();

        // Randomized traffic, biased toward a few addresses to provoke collisions
        for (int n = 0; n < 400; n++) begin
            logic [5:0] aa, ba;
            aa = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            ba = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 aa, $urandom(),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ba, $urandom());
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
